// File: rtl/y86_imem_loader_if.sv
// Program-stream input and instruction-memory write port of the y86 loader.
// slave: the loader side; master: the stream source / memory side.
interface y86_imem_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/y86_imem_loader.sv
// Loads a framed program (LEN_LO, LEN_HI, payload, checksum) into instruction memory.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module y86_imem_loader #(
  parameter int MEM_BYTES      = 1024,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  y86_imem_loader_if.slave       bus,
  output logic                   cpu_run,
  output logic                   load_done,
  output logic                   load_err,
  output logic [1:0]             err_code,
  output logic [63:0]            prog_len
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] LEN_HI = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CSUM   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam int CNT_W = ADDR_W + 1;

  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [CNT_W-1:0] n_len;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] prog_len_r;
  logic [7:0]       csum;
  logic             xfer;
  logic [31:0]      n_rx32;
  logic             to_hit;

  assign bus.s_ready = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CSUM);
  assign xfer     = bus.s_valid && bus.s_ready;
  assign n_rx32   = {16'd0, bus.s_data, len_lo};
  assign cnt_nx   = cnt + CNT_W'(1);
  assign prog_len = 64'(prog_len_r);

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.s_ready || xfer) to_cnt <= '0;
    else                                to_cnt <= to_cnt + 32'd1;
  end

  assign to_hit = bus.s_ready && !xfer && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  // Timeout disabled: constant-false expression keeps the parameter referenced.
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      len_lo         <= '0;
      n_len          <= '0;
      cnt            <= '0;
      csum           <= '0;
      prog_len_r     <= '0;
      cpu_run        <= 1'b0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      err_code       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state      <= LEN_LO;
            cnt        <= '0;
            csum       <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            err_code   <= '0;
            prog_len_r <= '0;
            cpu_run    <= 1'b0;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len_lo <= bus.s_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            n_len <= n_rx32[CNT_W-1:0];
            if (n_rx32 > 32'(MEM_BYTES)) begin
              state    <= ERR;
              load_err <= 1'b1;
              err_code <= 2'd1;
            end else if (n_rx32 == 32'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= cnt[ADDR_W-1:0];
            bus.imem_wdata <= bus.s_data;
            cnt            <= cnt_nx;
            csum           <= csum + bus.s_data;
            if (cnt_nx == n_len) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            if (bus.s_data == csum) begin
              state      <= DONE;
              load_done  <= 1'b1;
              prog_len_r <= n_len;
              cpu_run    <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
              err_code <= 2'd2;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Only fires on a no-transfer cycle, so it never races a state advance above.
      if (to_hit) begin
        state    <= ERR;
        load_err <= 1'b1;
        err_code <= 2'd3;
      end
    end
  end
endmodule
